pipeline_stall_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage MIPS pipeline. Decides every cycle whether each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds or takes a bubble. Resolves three hazard classes:
- load-use hazards;
- taken-branch fetch squash;
- multi-cycle data-memory accesses via a req/ack handshake with a timeout.

It sits beside the pipeline registers and drives their enable/flush inputs and the PC enable.

---
 rtl/pipeline_stall_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, taken-branch squash, dmem wait with timeout trap.
// Optional stall counter output enabled by defining PIPE_STALL_CNT_EN.
module pipeline_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_branch_taken,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       mem_access,
    input  logic       dmem_ack,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       memwb_bubble,
    output logic       dmem_req,
    output logic       bus_err
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_ERROR
    } state_e;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        load_use;
    logic        mem_stall;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        mem_stall    = 1'b0;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        dmem_req     = 1'b0;
        bus_err      = 1'b0;

        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                mem_stall = ((state_q == ST_MEM_WAIT) || mem_access) && !dmem_ack;
                if (mem_stall) begin
                    dmem_req     = 1'b1;
                    memwb_en     = 1'b1;
                    memwb_bubble = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = 16'd1;
                    end else if (wait_cnt_q == TIMEOUT_W) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                end else begin
                    // Release cycle re-evaluates ID hazards: frozen registers still present them.
                    dmem_req   = mem_access || (state_q == ST_MEM_WAIT);
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    if (load_use) begin
                        idex_flush = 1'b1;
                    end else begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = id_branch_taken;
                    end
                end
            end
            default: begin
                bus_err = 1'b1;
            end
        endcase

        if (!reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            memwb_bubble = 1'b0;
            dmem_req     = 1'b0;
            bus_err      = 1'b0;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != ST_ERROR) && !pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed hazard scenarios plus randomized traffic against a cycle model.
module tb_pipeline_stall_ctrl;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, id_branch_taken, ex_memread, mem_access, dmem_ack;
    logic       pc_en, ifid_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, memwb_bubble, dmem_req, bus_err;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: wait cycles already spent on the current access, trap flag, stall total.
    int unsigned     m_waits = 0;
    bit              m_trap  = 1'b0;
    longint unsigned m_stalls = 0;

    pipeline_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_access(mem_access), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .dmem_req(dmem_req), .bus_err(bus_err)
`ifdef PIPE_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Vector order: pc_en ifid_en exmem_en memwb_en | ifid_flush idex_flush memwb_bubble | dmem_req | bus_err
    function automatic logic [8:0] obs();
        return {pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble, dmem_req, bus_err};
    endfunction

    function automatic logic [8:0] model_out();
        logic lu, req;
        if (!reset) return 9'b0000_000_0_0;
        if (m_trap) return 9'b0000_000_0_1;
        if ((m_waits > 0 || mem_access) && !dmem_ack) return 9'b0001_001_1_0;
        lu  = ex_memread && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
        req = (m_waits > 0) || mem_access;
        if (lu) return {7'b0011_010, req, 1'b0};
        if (id_branch_taken) return {7'b1111_100, req, 1'b0};
        return {7'b1111_000, req, 1'b0};
    endfunction

    function automatic logic [31:0] exp_stalls();
        return reset ? m_stalls[31:0] : 32'd0;
    endfunction

    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic br, input logic mr, input logic [4:0] rd, input logic ma, input logic ack);
        @(negedge clk);
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = uses; id_branch_taken = br;
        ex_memread = mr; ex_rd = rd; mem_access = ma; dmem_ack = ack;
        #2;
    endtask

    task automatic tick();
        logic [8:0] e;
        e = model_out();
        @(posedge clk);
        if (!reset) begin
            m_waits = 0; m_trap = 1'b0; m_stalls = 0;
        end else if (!m_trap) begin
            if (!e[8] && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            if (e[2]) begin
                if (m_waits == TO) m_trap = 1'b1;
                else m_waits++;
            end else begin
                m_waits = 0;
            end
        end
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        logic [8:0] o;
        drive(0, 5'd3, 5'd3, 1, 1, 1, 5'd3, 1, 0);
        o = obs(); n_checks++;
        if (o !== 9'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", o, 9'b0); end
        tick();
`ifdef PIPE_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cycles); end
`endif
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_0_0) begin n_fail++; $display("FAIL reset_release_run: got %b expected %b", o, 9'b1111_000_0_0); end
        tick();
    endtask

    task automatic test_load_use();
        logic [8:0] o;
        pulse_reset();
        drive(1, 5'd5, 5'd9, 0, 0, 1, 5'd5, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b0011_010_0_0) begin n_fail++; $display("FAIL load_use_stall: got %b expected %b", o, 9'b0011_010_0_0); end
        tick();
        drive(1, 5'd5, 5'd9, 0, 0, 0, 5'd0, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_0_0) begin n_fail++; $display("FAIL load_use_next: got %b expected %b", o, 9'b1111_000_0_0); end
        tick();
`ifdef PIPE_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cycles); end
`endif
        drive(1, 5'd7, 5'd12, 1, 0, 1, 5'd12, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b0011_010_0_0) begin n_fail++; $display("FAIL load_use_rt: got %b expected %b", o, 9'b0011_010_0_0); end
        tick();
    endtask

    task automatic test_no_hazard();
        logic [8:0] o;
        drive(1, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_0_0) begin n_fail++; $display("FAIL load_use_r0: got %b expected %b", o, 9'b1111_000_0_0); end
        tick();
        drive(1, 5'd4, 5'd8, 0, 0, 1, 5'd8, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_0_0) begin n_fail++; $display("FAIL load_use_unused_rt: got %b expected %b", o, 9'b1111_000_0_0); end
        tick();
    endtask

    task automatic test_branch();
        logic [8:0] o;
        drive(1, 5'd1, 5'd2, 1, 1, 0, 5'd1, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b1111_100_0_0) begin n_fail++; $display("FAIL branch_squash: got %b expected %b", o, 9'b1111_100_0_0); end
        tick();
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd1, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b0011_010_0_0) begin n_fail++; $display("FAIL branch_vs_load_use: got %b expected %b", o, 9'b0011_010_0_0); end
        tick();
    endtask

    task automatic test_mem_wait();
        logic [8:0] o;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0, 1, 0);
            o = obs(); n_checks++;
            if (o !== 9'b0001_001_1_0) begin n_fail++; $display("FAIL mem_wait_stall[%0d]: got %b expected %b", i, o, 9'b0001_001_1_0); end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_1_0) begin n_fail++; $display("FAIL mem_wait_release: got %b expected %b", o, 9'b1111_000_1_0); end
        tick();
`ifdef PIPE_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL mem_wait_cnt: got %0d expected 3", stall_cycles); end
`endif
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_1_0) begin n_fail++; $display("FAIL mem_ack_first: got %b expected %b", o, 9'b1111_000_1_0); end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_0_0) begin n_fail++; $display("FAIL stray_ack: got %b expected %b", o, 9'b1111_000_0_0); end
        tick();
    endtask

    task automatic test_timeout();
        logic [8:0] o;
        pulse_reset();
        for (int i = 0; i <= TO; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
            o = obs(); n_checks++;
            if (o !== 9'b0001_001_1_0) begin n_fail++; $display("FAIL timeout_wait[%0d]: got %b expected %b", i, o, 9'b0001_001_1_0); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 1, 0, 0, 1, i[0]);
            o = obs(); n_checks++;
            if (o !== 9'b0000_000_0_1) begin n_fail++; $display("FAIL timeout_error[%0d]: got %b expected %b", i, o, 9'b0000_000_0_1); end
            tick();
        end
        pulse_reset();
        for (int i = 0; i < TO; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_1_0) begin n_fail++; $display("FAIL timeout_ack_wins: got %b expected %b", o, 9'b1111_000_1_0); end
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_0_0) begin n_fail++; $display("FAIL timeout_after_ack: got %b expected %b", o, 9'b1111_000_0_0); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [8:0] o;
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        o = obs(); n_checks++;
        if (o !== 9'b0) begin n_fail++; $display("FAIL reset_mid_wait: got %b expected %b", o, 9'b0); end
`ifdef PIPE_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_mid_wait_cnt: got %0d expected 0", stall_cycles); end
`endif
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        o = obs(); n_checks++;
        if (o !== 9'b1111_000_0_0) begin n_fail++; $display("FAIL reset_mid_wait_run: got %b expected %b", o, 9'b1111_000_0_0); end
        tick();
    endtask

    task automatic test_random();
        logic [8:0] o, e;
        logic rst;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) != 0);
            drive(rst, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            o = obs(); e = model_out(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL random[%0d]: got %b expected %b", i, o, e); end
`ifdef PIPE_STALL_CNT_EN
            n_checks++;
            if (stall_cycles !== exp_stalls()) begin
                n_fail++; $display("FAIL random_cnt[%0d]: got %0d expected %0d", i, stall_cycles, exp_stalls());
            end
`endif
            tick();
        end
    endtask

    initial begin
        reset = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rt = 1'b0; id_branch_taken = 1'b0; ex_memread = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
